// File: rtl/result_trace_fifo.sv
// Trace FIFO for datapath write-back results: captures {opcode, result} on qualified
// register writes, drains to a debug consumer, and counts captures dropped while full.
module result_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      datapath_result,
  input  logic [5:0]       inst_31_26,
  input  logic             reg_write,
  input  logic             capture_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [37:0]      out_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic [7:0]       drop_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [37:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic [7:0]       drop_q;

  logic push;
  logic pop;
  logic do_write;
  logic drop;

  assign push     = capture_en & reg_write;
  assign pop      = out_valid & out_ready;
  // When full, a simultaneous pop frees the head slot, so the capture still fits.
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign count     = count_q;
  assign out_valid = ~empty;
  assign out_data  = empty ? 38'd0 : mem[rd_ptr];
  assign overflow  = overflow_q;
  assign drop_count = drop_q;

  // Storage is not reset; occupancy gating hides stale entries.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      mem[wr_ptr] <= {inst_31_26, datapath_result};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)      rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_write, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

endmodule
